// File: rtl/message_comm_rx_core.sv
// FSX-framed multi-lane link receiver: deserialises lanes into a one-frame buffer, checks the
// trailing CRC-8 and streams the accepted payload over valid/ready with sop/eop.
module message_comm_rx_core #(
  parameter int unsigned LANES  = 4,
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned CRC_EN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              msg_rx_fsx_i,
  input  logic [LANES-1:0]  msg_rx_lane_i,
  output logic [7:0]        m_data_o,
  output logic              m_vld_o,
  input  logic              m_ready_i,
  output logic              m_sop_o,
  output logic              m_eop_o,
  output logic [ADDR_W:0]   frame_len_o,
  output logic              frame_ok_o,
  output logic              crc_err_o,
  output logic              frm_err_o,
  output logic              ovf_err_o,
  output logic              drop_err_o,
  output logic              busy_o,
  output logic [15:0]       err_cnt_o
);

  localparam int unsigned BeatsPerByte = 8 / LANES;
  localparam int unsigned Depth        = 1 << ADDR_W;
  localparam int unsigned MinBytes     = (CRC_EN != 0) ? 2 : 1;
  localparam int unsigned CntW         = ADDR_W + 1;

  typedef enum logic [2:0] {StIdle, StRecv, StCheck, StRead, StSkip} state_e;

  state_e            state_q, state_d;
  logic              fsx_q;
  logic [2:0]        bcnt_q, bcnt_d;
  logic [CntW-1:0]   byte_cnt_q, byte_cnt_d;
  logic [7:0]        sh_q, sh_d;
  logic [7:0]        last_q, last_d;
  logic [7:0]        crc_q, crc_d;
  logic              ovf_q, ovf_d;

  logic [CntW-1:0]   rd_ptr_q, rd_ptr_d;
  logic              ram_vld_q, ram_vld_d;
  logic              ram_first_q, ram_first_d;
  logic              ram_last_q, ram_last_d;
  logic [7:0]        ram_rdata_q;
  logic              m_vld_q, m_vld_d;
  logic [7:0]        m_data_q, m_data_d;
  logic              m_sop_q, m_sop_d;
  logic              m_eop_q, m_eop_d;
  logic [15:0]       err_cnt_q, err_cnt_d;

  logic [7:0]        mem [Depth];

  function automatic logic [7:0] crc8_byte(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    logic       fb;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      fb = r[7] ^ d[i];
      r  = {r[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    end
    return r;
  endfunction

  // Deserialiser
  logic              fsx_rise, start, capture, byte_done, wr_en;
  logic [2:0]        bcnt_base;
  logic [CntW-1:0]   cnt_base;
  logic [7+LANES:0]  shifted;
  logic [7:0]        new_byte;

  assign fsx_rise  = msg_rx_fsx_i & ~fsx_q;
  assign start     = (state_q == StIdle) && fsx_rise;
  assign capture   = start || ((state_q == StRecv) && msg_rx_fsx_i);
  assign bcnt_base = start ? 3'd0 : bcnt_q;
  assign cnt_base  = start ? '0 : byte_cnt_q;
  assign shifted   = {sh_q, msg_rx_lane_i};
  assign new_byte  = shifted[7:0];
  assign byte_done = capture && (bcnt_base == 3'(BeatsPerByte - 1));
  assign wr_en     = byte_done && (cnt_base != CntW'(Depth));

  always_comb begin
    sh_d       = sh_q;
    bcnt_d     = bcnt_q;
    byte_cnt_d = byte_cnt_q;
    crc_d      = crc_q;
    ovf_d      = ovf_q;
    last_d     = last_q;
    if (capture) begin
      sh_d       = new_byte;
      bcnt_d     = byte_done ? 3'd0 : bcnt_base + 3'd1;
      byte_cnt_d = cnt_base;
      crc_d      = start ? 8'hFF : crc_q;
      ovf_d      = start ? 1'b0 : ovf_q;
      if (byte_done) begin
        if (cnt_base == CntW'(Depth)) begin
          ovf_d = 1'b1;
        end else begin
          byte_cnt_d = cnt_base + CntW'(1);
        end
        // CRC lags one byte so the final byte is always the received checksum
        if (cnt_base != '0) begin
          crc_d = crc8_byte(crc_d, last_q);
        end
        last_d = new_byte;
      end
    end
  end

  // Frame check
  logic            in_check, frm_bad, crc_bad;
  logic            res_ovf, res_frm, res_crc, res_ok;
  logic [CntW-1:0] payload_len;

  assign in_check = (state_q == StCheck);
  assign frm_bad  = (bcnt_q != 3'd0) || (byte_cnt_q < CntW'(MinBytes));
  assign crc_bad  = (CRC_EN != 0) && (last_q != crc_q);
  assign res_ovf  = ovf_q;
  assign res_frm  = !ovf_q && frm_bad;
  assign res_crc  = !ovf_q && !frm_bad && crc_bad;
  assign res_ok   = !ovf_q && !frm_bad && !crc_bad;

  always_comb begin
    payload_len = byte_cnt_q;
    if (CRC_EN != 0) begin
      payload_len = (byte_cnt_q == '0) ? '0 : byte_cnt_q - CntW'(1);
    end
  end

  // Read pipeline: RAM register stage followed by the output register
  logic out_accept, reading, rd_en, eop_hs;

  assign out_accept = !m_vld_q || m_ready_i;
  assign reading    = (in_check && res_ok) || (state_q == StRead);
  assign rd_en      = reading && (rd_ptr_q < payload_len) && (!ram_vld_q || out_accept);
  assign eop_hs     = (state_q == StRead) && m_vld_q && m_eop_q && m_ready_i;

  always_comb begin
    rd_ptr_d    = rd_ptr_q;
    ram_vld_d   = ram_vld_q;
    ram_first_d = ram_first_q;
    ram_last_d  = ram_last_q;
    m_vld_d     = m_vld_q;
    m_data_d    = m_data_q;
    m_sop_d     = m_sop_q;
    m_eop_d     = m_eop_q;
    if (!reading || eop_hs) begin
      rd_ptr_d  = '0;
      ram_vld_d = 1'b0;
      m_vld_d   = 1'b0;
      m_sop_d   = 1'b0;
      m_eop_d   = 1'b0;
    end else begin
      if (rd_en) begin
        rd_ptr_d    = rd_ptr_q + CntW'(1);
        ram_vld_d   = 1'b1;
        ram_first_d = (rd_ptr_q == '0);
        ram_last_d  = (rd_ptr_q == payload_len - CntW'(1));
      end else if (out_accept) begin
        ram_vld_d = 1'b0;
      end
      if (out_accept) begin
        m_vld_d  = ram_vld_q;
        m_data_d = ram_rdata_q;
        m_sop_d  = ram_first_q;
        m_eop_d  = ram_last_q;
      end
    end
  end

  // FSM
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        // FSX already high (only possible right after reset) means a partial frame
        if (msg_rx_fsx_i) state_d = fsx_q ? StSkip : StRecv;
      end
      StRecv: begin
        if (!msg_rx_fsx_i) state_d = StCheck;
      end
      StCheck: begin
        if (res_ok)            state_d = StRead;
        else if (msg_rx_fsx_i) state_d = StSkip;
        else                   state_d = StIdle;
      end
      StRead: begin
        if (eop_hs) state_d = msg_rx_fsx_i ? StSkip : StIdle;
      end
      StSkip: begin
        if (!msg_rx_fsx_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Error reporting
  logic [1:0]  err_inc;
  logic [16:0] err_sum;

  assign frame_ok_o = in_check && res_ok;
  assign crc_err_o  = in_check && res_crc;
  assign frm_err_o  = in_check && res_frm;
  assign ovf_err_o  = in_check && res_ovf;
  assign drop_err_o = ((state_q == StCheck) || (state_q == StRead)) && fsx_rise;

  always_comb begin
    err_inc   = {1'b0, crc_err_o} + {1'b0, frm_err_o} + {1'b0, ovf_err_o} + {1'b0, drop_err_o};
    err_sum   = {1'b0, err_cnt_q} + 17'(err_inc);
    err_cnt_d = err_sum[16] ? 16'hFFFF : err_sum[15:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      fsx_q       <= 1'b1;
      bcnt_q      <= 3'd0;
      byte_cnt_q  <= '0;
      sh_q        <= 8'h00;
      last_q      <= 8'h00;
      crc_q       <= 8'hFF;
      ovf_q       <= 1'b0;
      rd_ptr_q    <= '0;
      ram_vld_q   <= 1'b0;
      ram_first_q <= 1'b0;
      ram_last_q  <= 1'b0;
      m_vld_q     <= 1'b0;
      m_data_q    <= 8'h00;
      m_sop_q     <= 1'b0;
      m_eop_q     <= 1'b0;
      err_cnt_q   <= 16'h0000;
    end else begin
      state_q     <= state_d;
      fsx_q       <= msg_rx_fsx_i;
      bcnt_q      <= bcnt_d;
      byte_cnt_q  <= byte_cnt_d;
      sh_q        <= sh_d;
      last_q      <= last_d;
      crc_q       <= crc_d;
      ovf_q       <= ovf_d;
      rd_ptr_q    <= rd_ptr_d;
      ram_vld_q   <= ram_vld_d;
      ram_first_q <= ram_first_d;
      ram_last_q  <= ram_last_d;
      m_vld_q     <= m_vld_d;
      m_data_q    <= m_data_d;
      m_sop_q     <= m_sop_d;
      m_eop_q     <= m_eop_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[cnt_base[ADDR_W-1:0]] <= new_byte;
    if (rd_en) ram_rdata_q <= mem[rd_ptr_q[ADDR_W-1:0]];
  end

  assign m_data_o    = m_data_q;
  assign m_vld_o     = m_vld_q;
  assign m_sop_o     = m_sop_q;
  assign m_eop_o     = m_eop_q;
  assign frame_len_o = ((state_q == StCheck) || (state_q == StRead)) ? payload_len : '0;
  assign busy_o      = (state_q == StCheck) || (state_q == StRead) || (state_q == StSkip);
  assign err_cnt_o   = err_cnt_q;

endmodule

// File: tb/tb_message_comm_rx_core.sv
// Directed bench for message_comm_rx_core (LANES=4, 16-byte buffer, CRC enabled): frame table
// plus hand-written stall/drop and reset-mid-frame sequences.
module tb_message_comm_rx_core;

  localparam int unsigned Lanes = 4;
  localparam int unsigned AddrW = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             fsx;
  logic [Lanes-1:0] lane;
  logic             m_ready;
  logic [7:0]       m_data;
  logic             m_vld, m_sop, m_eop;
  logic [AddrW:0]   frame_len;
  logic             frame_ok, crc_err, frm_err, ovf_err, drop_err, busy;
  logic [15:0]      err_cnt;

  message_comm_rx_core #(.LANES(Lanes), .ADDR_W(AddrW), .CRC_EN(1)) dut (
    .clk          (clk),
    .rst          (rst),
    .msg_rx_fsx_i (fsx),
    .msg_rx_lane_i(lane),
    .m_data_o     (m_data),
    .m_vld_o      (m_vld),
    .m_ready_i    (m_ready),
    .m_sop_o      (m_sop),
    .m_eop_o      (m_eop),
    .frame_len_o  (frame_len),
    .frame_ok_o   (frame_ok),
    .crc_err_o    (crc_err),
    .frm_err_o    (frm_err),
    .ovf_err_o    (ovf_err),
    .drop_err_o   (drop_err),
    .busy_o       (busy),
    .err_cnt_o    (err_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Output monitor, sampled on the falling edge
  int         cyc = 0, n_ok = 0, n_crc = 0, n_frm = 0, n_ovf = 0, n_drop = 0;
  int         ok_cyc = 0, ok_len = 0, rise_cyc = 0, hold_bad = 0;
  logic       prev_vld = 1'b0, prev_stall = 1'b0;
  logic [9:0] prev_out = '0;
  logic [9:0] outs [$];

  always @(negedge clk) begin
    cyc++;
    if (frame_ok) begin n_ok++; ok_cyc = cyc; ok_len = int'(frame_len); end
    if (crc_err)  n_crc++;
    if (frm_err)  n_frm++;
    if (ovf_err)  n_ovf++;
    if (drop_err) n_drop++;
    if (m_vld && !prev_vld) rise_cyc = cyc;
    if (prev_stall && (!m_vld || {m_sop, m_eop, m_data} != prev_out)) hold_bad++;
    if (m_vld && m_ready) outs.push_back({m_sop, m_eop, m_data});
    prev_stall = m_vld && !m_ready;
    prev_out   = {m_sop, m_eop, m_data};
    prev_vld   = m_vld;
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  logic [7:0] fr [32];

  function automatic logic [7:0] crc_model(input int n);
    logic [7:0] c;
    c = 8'hFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ fr[i];
      for (int j = 0; j < 8; j++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    return c;
  endfunction

  task automatic tick_in(input logic f, input logic [Lanes-1:0] l);
    fsx  = f;
    lane = l;
    @(posedge clk);
    #1;
  endtask

  // Sends fr[0..n-1] MSB nibble first, then `extra` stray beats, then drops FSX for one beat
  task automatic send_frame(input int n, input int extra);
    for (int i = 0; i < n; i++) begin
      tick_in(1'b1, fr[i][7:4]);
      tick_in(1'b1, fr[i][3:0]);
    end
    for (int i = 0; i < extra; i++) tick_in(1'b1, 4'hA);
    tick_in(1'b0, 4'h0);
  endtask

  task automatic wait_idle(input string name);
    int i;
    for (i = 0; i < 300; i++) begin
      if (!busy && !m_vld) break;
      @(posedge clk);
      #1;
    end
    check(name, int'(i < 300), 1);
  endtask

  typedef struct {
    int         plen;
    logic [7:0] seed;
    int         crc_mode;  // 0 computed, 1 fixed, 2 computed and corrupted
    logic [7:0] fcrc;
    int         extra;
    bit         e_ok, e_crc, e_frm, e_ovf;
  } vec_t;

  vec_t vecs [10];

  int s_ok, s_crc, s_frm, s_ovf, s_drop, s_out, s_err, s_hold;

  task automatic snap();
    s_ok = n_ok; s_crc = n_crc; s_frm = n_frm; s_ovf = n_ovf; s_drop = n_drop;
    s_out = outs.size(); s_err = int'(err_cnt); s_hold = hold_bad;
  endtask

  task automatic check_payload(input string name, input int plen);
    int got;
    got = outs.size() - s_out;
    check({name, "_count"}, got, plen);
    for (int i = 0; i < plen && i < got; i++) begin
      check({name, "_byte"}, int'(outs[s_out + i]),
            int'({i == 0, i == plen - 1, fr[i]}));
    end
  endtask

  initial begin
    vecs[0] = '{1,  8'h00, 1, 8'hF3, 0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1,  8'h00, 1, 8'hF4, 0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{5,  8'h11, 0, 8'h00, 1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{0,  8'h00, 1, 8'hAB, 0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{17, 8'h22, 2, 8'h00, 0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{15, 8'h33, 0, 8'h00, 0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{4,  8'h5A, 0, 8'h00, 0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{2,  8'h77, 2, 8'h00, 1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[8] = '{3,  8'hC3, 2, 8'h00, 0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[9] = '{1,  8'hFF, 0, 8'h00, 0, 1'b1, 1'b0, 1'b0, 1'b0};

    rst = 1'b1; fsx = 1'b0; lane = '0; m_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_vld", int'(m_vld), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_errcnt", int'(err_cnt), 0);
    check("rst_pulses", int'({frame_ok, crc_err, frm_err, ovf_err, drop_err, m_sop, m_eop}), 0);
    check("rst_len", int'(frame_len), 0);
    rst = 1'b0;
    repeat (2) tick_in(1'b0, 4'h0);
    check("idle_busy", int'(busy), 0);

    // Frame table
    for (int v = 0; v < 10; v++) begin
      for (int i = 0; i < vecs[v].plen; i++) fr[i] = 8'(vecs[v].seed + 8'(i * 37));
      case (vecs[v].crc_mode)
        0:       fr[vecs[v].plen] = crc_model(vecs[v].plen);
        1:       fr[vecs[v].plen] = vecs[v].fcrc;
        default: fr[vecs[v].plen] = crc_model(vecs[v].plen) ^ 8'h01;
      endcase
      snap();
      send_frame(vecs[v].plen + 1, vecs[v].extra);
      wait_idle("vec_idle");
      check("vec_ok",   n_ok - s_ok,   int'(vecs[v].e_ok));
      check("vec_crc",  n_crc - s_crc, int'(vecs[v].e_crc));
      check("vec_frm",  n_frm - s_frm, int'(vecs[v].e_frm));
      check("vec_ovf",  n_ovf - s_ovf, int'(vecs[v].e_ovf));
      check("vec_errcnt", int'(err_cnt) - s_err,
            int'(vecs[v].e_crc) + int'(vecs[v].e_frm) + int'(vecs[v].e_ovf));
      if (vecs[v].e_ok) begin
        check("vec_len", ok_len, vecs[v].plen);
        check("vec_latency", rise_cyc - ok_cyc, 2);
        check_payload("vec_out", vecs[v].plen);
      end else begin
        check("vec_no_out", outs.size() - s_out, 0);
      end
      tick_in(1'b0, 4'h0);
    end

    // Backpressure 1-0-0-1 with a colliding frame arriving during READ
    begin
      logic pat [4];
      int   k;
      pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
      for (int i = 0; i < 4; i++) fr[i] = 8'(8'h3C + 8'(i * 29));
      fr[4] = crc_model(4);
      snap();
      m_ready = 1'b0;
      send_frame(5, 0);
      for (k = 0; k < 20 && !m_vld; k++) tick_in(1'b0, 4'h0);
      check("stall_vld_seen", int'(m_vld), 1);
      for (int c = 0; c < 13; c++) begin
        m_ready = pat[c % 4];
        if (c == 8) begin
          check("skip_busy", int'(busy), 1);
          check("skip_vld", int'(m_vld), 0);
        end
        tick_in(c >= 2 && c <= 9, 4'(c));
      end
      m_ready = 1'b1;
      check("skip_exit", int'(busy), 0);
      check("stall_ok", n_ok - s_ok, 1);
      check("stall_drop", n_drop - s_drop, 1);
      check("stall_other", (n_crc - s_crc) + (n_frm - s_frm) + (n_ovf - s_ovf), 0);
      check("stall_hold", hold_bad - s_hold, 0);
      check("stall_errcnt", int'(err_cnt) - s_err, 1);
      check_payload("stall_out", 4);
    end

    // Reset in the middle of a frame, released with FSX still high
    snap();
    for (int i = 0; i < 5; i++) tick_in(1'b1, 4'(i + 3));
    rst = 1'b1;
    #1;
    check("midrst_vld", int'(m_vld), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_errcnt", int'(err_cnt), 0);
    tick_in(1'b1, 4'h5);
    tick_in(1'b1, 4'h6);
    rst = 1'b0;
    tick_in(1'b1, 4'h7);
    check("midrst_skip", int'(busy), 1);
    for (int i = 0; i < 3; i++) tick_in(1'b1, 4'h9);
    tick_in(1'b0, 4'h0);
    tick_in(1'b0, 4'h0);
    check("midrst_idle", int'(busy), 0);
    check("midrst_pulses",
          (n_ok - s_ok) + (n_crc - s_crc) + (n_frm - s_frm) + (n_ovf - s_ovf) + (n_drop - s_drop), 0);
    check("midrst_no_out", outs.size() - s_out, 0);
    fr[0] = 8'h81; fr[1] = 8'h42;
    fr[2] = crc_model(2);
    snap();
    send_frame(3, 0);
    wait_idle("post_idle");
    check("post_ok", n_ok - s_ok, 1);
    check("post_len", ok_len, 2);
    check_payload("post_out", 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
